rv32i_dmem_arbiter: RTL and testbench

//   Shares the single-port 32x32 data memory between the pipeline MEM stage (LW/SW) and a debug/loader port.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/rv32i_arb_hold_ctr.sv | 30 +++
 rtl/rv32i_dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_rv32i_dmem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared types and sizes for the RV32I data-memory arbiter slice.
package rv32i_pkg;

    localparam int DMEM_DEPTH = 32;
    localparam int XLEN       = 32;

    // Owner of the read issued in the previous cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CORE = 2'd1,
        RD_DBG  = 2'd2
    } arb_state_t;

    // Which requester won the memory port this cycle.
    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

endpackage

// File: rtl/rv32i_arb_hold_ctr.sv
// Saturating starvation counter: counts consecutive core wins while the debug
// port waits, and flags when debug must be forced through.
module rv32i_arb_hold_ctr #(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] cnt_reg;

    assign expired = (cnt_reg == CNT_W'(MAX_HOLD));

    // Clear has priority; increment saturates at MAX_HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && !expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/rv32i_dmem_arbiter.sv
// Arbitrates the single-port data memory between the core MEM stage and the
// debug/loader port. Core has priority; the hold counter guarantees debug a
// slot after MAX_HOLD consecutive core wins. Read data is returned one cycle
// after grant to whichever requester issued the read.
// Optional feature: define DMEM_ARB_RANGE_CHK_EN to reject addresses >= DEPTH
// (retired without a memory access, addr_err pulsed). Otherwise addresses wrap.
module rv32i_dmem_arbiter
    import rv32i_pkg::*;
#(
    parameter int DEPTH    = DMEM_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int DATA_W   = XLEN,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              RN,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              addr_err
);

    arb_state_t        state_reg;
    owner_t            winner;
    logic              expired;
    logic              core_sel;
    logic              dbg_sel;
    logic              any_gnt;
    logic              win_we;
    logic [31:0]       win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              rd_fire;
    logic [DATA_W-1:0] core_rdata_reg;
    logic [DATA_W-1:0] dbg_rdata_reg;

    // Grants are suppressed while reset is asserted so nothing is granted
    // in the same cycle reset arrives.
    always_comb begin
        core_sel = 1'b0;
        dbg_sel  = 1'b0;
        if (!RN) begin
            core_sel = core_req & (~dbg_req | ~expired);
            dbg_sel  = dbg_req  & (~core_req | expired);
        end
    end

    assign winner    = dbg_sel ? OWN_DBG : OWN_CORE;
    assign any_gnt   = core_sel | dbg_sel;
    assign win_we    = (winner == OWN_DBG) ? dbg_we    : core_we;
    assign win_addr  = (winner == OWN_DBG) ? dbg_addr  : core_addr;
    assign win_wdata = (winner == OWN_DBG) ? dbg_wdata : core_wdata;

    assign core_gnt   = core_sel;
    assign dbg_gnt    = dbg_sel;
    assign core_stall = core_req & ~core_gnt;

    assign mem_we    = mem_en & win_we;
    assign mem_addr  = win_addr[ADDR_W-1:0];
    assign mem_wdata = win_wdata;
    assign rd_fire   = mem_en & ~win_we;

`ifdef DMEM_ARB_RANGE_CHK_EN
    logic addr_oob;
    logic addr_err_reg;

    // Out-of-range requests are retired (granted) but never touch memory.
    assign addr_oob = any_gnt & (win_addr >= 32'(DEPTH));
    assign mem_en   = any_gnt & ~addr_oob;
    assign addr_err = addr_err_reg;

    // One-cycle error pulse following a rejected access.
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= addr_oob;
        end
    end
`else
    logic unused_addr_hi;

    // Upper address bits are dropped: the address wraps within the array.
    assign unused_addr_hi = ^win_addr[31:ADDR_W];
    assign mem_en         = any_gnt;
    assign addr_err       = 1'b0;
`endif

    // Starvation counter: count core wins over a waiting debug port, clear
    // whenever debug wins or stops asking.
    rv32i_arb_hold_ctr #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_ctr (
        .clk     (clk),
        .rst     (RN),
        .inc     (core_sel & dbg_req),
        .clr     (dbg_sel | ~dbg_req),
        .expired (expired)
    );

    // Track owner of the read issued this cycle; writes and idle cycles
    // return to IDLE so a write never produces read data.
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            state_reg <= IDLE;
        end else if (rd_fire) begin
            state_reg <= (winner == OWN_DBG) ? RD_DBG : RD_CORE;
        end else begin
            state_reg <= IDLE;
        end
    end

    // Capture delivered read data so each port holds its last value.
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            core_rdata_reg <= '0;
            dbg_rdata_reg  <= '0;
        end else begin
            if (state_reg == RD_CORE) core_rdata_reg <= mem_rdata;
            if (state_reg == RD_DBG)  dbg_rdata_reg  <= mem_rdata;
        end
    end

    assign core_rvalid = (state_reg == RD_CORE);
    assign dbg_rvalid  = (state_reg == RD_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_reg;
    assign dbg_rdata   = dbg_rvalid  ? mem_rdata : dbg_rdata_reg;

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Testbench for rv32i_dmem_arbiter: directed stimulus, read responses checked
// by a scoreboard monitor, grant/strobe behaviour checked inline.
module tb_rv32i_dmem_arbiter;

    logic        clk;
    logic        RN;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic        core_gnt, core_rvalid, core_stall, dbg_gnt, dbg_rvalid;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_en, mem_we, addr_err;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem_array [32];

    typedef struct {
        logic        is_dbg;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;

    rv32i_dmem_arbiter dut (
        .clk         (clk),
        .RN          (RN),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_stall  (core_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port data memory with registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_array[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_array[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Read-response monitor: pops the scoreboard whenever the DUT returns data.
    always @(negedge clk) begin
        exp_t e;
        if (!RN) begin
            if (core_rvalid && dbg_rvalid) chk("rvalid_collision", 32'(core_rvalid & dbg_rvalid), 32'd0);
            if (core_rvalid || dbg_rvalid) begin
                chk("rvalid_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("rvalid_owner", 32'(dbg_rvalid), 32'(e.is_dbg));
                    chk("rdata", dbg_rvalid ? dbg_rdata : core_rdata, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_req  = 0; dbg_we  = 0; dbg_addr  = 0; dbg_wdata  = 0;
    endtask

    task automatic set_core(input logic we, input logic [31:0] a, input logic [31:0] d);
        core_req = 1; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_dbg(input logic we, input logic [31:0] a, input logic [31:0] d);
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic push(input logic is_dbg, input logic [31:0] d);
        exp_t e;
        e.is_dbg = is_dbg;
        e.data   = d;
        sb_q.push_back(e);
    endtask

    logic [5:0] pat_core;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) mem_array[i] = 32'h0;
        mem_array[1] = 32'h11;
        mem_array[2] = 32'h22;
        mem_array[8] = 32'h88;
        mem_rdata    = 32'h0;
        RN = 1'b1;
        idle();
        core_req = 1; dbg_req = 1;

        // Reset state with both requests raised.
        @(negedge clk);
        chk("rst_core_gnt", 32'(core_gnt), 0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_rvalid", 32'({core_rvalid, dbg_rvalid}), 0);
        chk("rst_addr_err", 32'(addr_err), 0);
        step(); RN = 1'b0; idle();

        // Core store then load of word 3.
        set_core(1, 3, 32'hDEAD);
        @(negedge clk);
        chk("sw_core_gnt", 32'(core_gnt), 1);
        chk("sw_mem_we", 32'(mem_we), 1);
        chk("sw_mem_addr", 32'(mem_addr), 3);
        chk("sw_mem_wdata", mem_wdata, 32'hDEAD);
        step(); set_core(0, 3, 0);
        @(negedge clk);
        chk("lw_core_gnt", 32'(core_gnt), 1);
        chk("lw_mem_we", 32'(mem_we), 0);
        chk("lw_no_early_rvalid", 32'(core_rvalid), 0);
        push(0, 32'hDEAD);
        step(); idle();
        @(negedge clk);
        chk("lw_rvalid", 32'(core_rvalid), 1);

        // Alternating reads: core word 1, then debug word 2.
        step(); set_core(0, 1, 0);
        @(negedge clk); push(0, 32'h11);
        step(); idle(); set_dbg(0, 2, 0);
        @(negedge clk); push(1, 32'h22);
        chk("alt_core_rvalid", 32'(core_rvalid), 1);
        chk("alt_dbg_gnt", 32'(dbg_gnt), 1);
        step(); idle();
        @(negedge clk);
        chk("alt_dbg_rvalid", 32'(dbg_rvalid), 1);
        chk("alt_core_rdata_hold", core_rdata, 32'h11);
        step();
        @(negedge clk);
        chk("alt_dbg_rdata_hold", dbg_rdata, 32'h22);
        chk("alt_dbg_rvalid_low", 32'(dbg_rvalid), 0);

        // Contention: four core wins, then debug forced, then core again.
        pat_core = 6'b101111;
        for (int i = 0; i < 6; i++) begin
            step(); set_core(1, 10, 32'hC0 + 32'(i)); set_dbg(1, 11, 32'hD0 + 32'(i));
            @(negedge clk);
            chk($sformatf("hold_core_gnt_%0d", i), 32'(core_gnt), 32'(pat_core[i]));
            chk($sformatf("hold_dbg_gnt_%0d", i), 32'(dbg_gnt), 32'(!pat_core[i]));
            chk($sformatf("hold_stall_%0d", i), 32'(core_stall), 32'(!pat_core[i]));
        end
        step(); idle();

        // Out-of-range core load to address 40.
        set_core(0, 40, 0);
        @(negedge clk);
        chk("oob_core_gnt", 32'(core_gnt), 1);
`ifdef DMEM_ARB_RANGE_CHK_EN
        chk("oob_mem_en", 32'(mem_en), 0);
        step(); idle();
        @(negedge clk);
        chk("oob_addr_err", 32'(addr_err), 1);
        chk("oob_no_rvalid", 32'(core_rvalid), 0);
`else
        chk("wrap_mem_en", 32'(mem_en), 1);
        chk("wrap_mem_addr", 32'(mem_addr), 8);
        push(0, 32'h88);
        step(); idle();
        @(negedge clk);
        chk("wrap_addr_err", 32'(addr_err), 0);
        chk("wrap_rvalid", 32'(core_rvalid), 1);
`endif

        // Debug alone: ten writes, every one granted, no core stall.
        for (int i = 0; i < 10; i++) begin
            step(); idle(); set_dbg(1, 16 + 32'(i), 32'h100 + 32'(i));
            @(negedge clk);
            chk($sformatf("dbg_only_gnt_%0d", i), 32'(dbg_gnt), 1);
            chk($sformatf("dbg_only_stall_%0d", i), 32'(core_stall), 0);
        end
        // Counter must be back at zero: core gets the full four wins.
        for (int i = 0; i < 5; i++) begin
            step(); set_core(1, 12, 0); set_dbg(1, 13, 0);
            @(negedge clk);
            chk($sformatf("post_dbg_core_gnt_%0d", i), 32'(core_gnt), (i < 4) ? 32'd1 : 32'd0);
        end
        step(); idle(); set_dbg(0, 19, 0);
        @(negedge clk); push(1, 32'h103);
        step(); idle();

        // Reset arriving while a core read response is pending.
        step(); set_core(0, 1, 0);
        @(negedge clk);
        chk("midrst_pre_gnt", 32'(core_gnt), 1);
        step(); RN = 1'b1; set_dbg(0, 2, 0);
        #1;
        chk("midrst_core_rvalid", 32'(core_rvalid), 0);
        chk("midrst_gnt", 32'({core_gnt, dbg_gnt}), 0);
        chk("midrst_mem_en", 32'(mem_en), 0);
        chk("midrst_addr_err", 32'(addr_err), 0);
        step(); RN = 1'b0; idle(); set_dbg(0, 2, 0);
        @(negedge clk); push(1, 32'h22);
        step(); idle();
        step(); step();

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
